cozy_mem_arbiter: RTL
=====================

Name: cozy_mem_arbiter

Overview:
Two-port arbiter that shares the single-port cozy block RAM between the CPU and the video/terminal scanout engine. Each cycle it grants at most one requester and drives the RAM address, write data and byte-write-enable from that requester. It steers the RAM's one-cycle-latency read data back to whichever requester issued the read. Video has fixed priority, and a CPU starvation counter bounds how long the CPU waits.

Parameters:
MAX_CPU_WAIT, 4, consecutive denied CPU-request cycles after which the CPU wins arbitration; 0 = CPU always has priority
WAIT_W, $clog2(MAX_CPU_WAIT+1) (min 1), width of the starvation counter

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  synchronous, active-low reset
cpu_req  in  1  CPU request; hold it, along with addr/wdata/bwe, stable until cpu_gnt
cpu_addr  in  16  CPU byte/word address (addr[0] selects byte for byte ops)
cpu_wdata  in  16  CPU write data (byte writes use [7:0])
cpu_bwe  in  2  00 read, 01 byte write, 11 word write
cpu_gnt  out  1  request accepted this cycle
cpu_rvalid  out  1  read data valid (one cycle after a CPU read grant)
cpu_rdata  out  16  read data, meaningful only while cpu_rvalid=1
vid_req  in  1  video read request (read-only port)
vid_addr  in  16  video read address
vid_gnt  out  1  request accepted this cycle
vid_rvalid  out  1  read data valid (one cycle after a video grant)
vid_rdata  out  16  read data, meaningful only while vid_rvalid=1
mem_addr  out  16  to RAM addr
mem_din  out  16  to RAM din
mem_bwe  out  2  to RAM bwe
mem_dout  in  16  from RAM dout (valid one cycle after the address is presented)

Behaviour:
- Grant is combinational in the same cycle as the request. A transaction completes on the cycle req&gnt=1. Back-to-back transactions are allowed every cycle.
- Priority:
  - If cpu_req and cpu_wait==MAX_CPU_WAIT, the CPU wins.
  - Otherwise, if vid_req, video wins.
  - Otherwise, if cpu_req, the CPU wins.
  - Otherwise, no grant.
- cpu_wait update, evaluated in this order:
  - Cleared to 0 on cpu_gnt or !cpu_req.
  - Otherwise, +1 each cycle with cpu_req&!cpu_gnt.
  - Saturates at MAX_CPU_WAIT.
- Memory outputs:
  - mem_addr, mem_din and mem_bwe are muxed from the granted requester.
  - A video grant forces mem_bwe=00 and mem_din=0.
  - No grant gives mem_bwe=00, with mem_addr and mem_din holding their last granted values (registered copy), so there are no spurious writes.
- cpu_bwe=10 is illegal and is normalized to 00: treated as a read, with rvalid asserted.
- Read tracking:
  - A 2-bit register owner_q is set to CPU/VID on a read grant and NONE otherwise.
  - cpu_rvalid = (owner_q==CPU); vid_rvalid = (owner_q==VID).
  - Both rdata outputs = mem_dout passthrough; zero-extension for odd byte reads comes from the RAM.
  - Writes never raise rvalid.
- Reset (rst_n=0 at a clock edge):
  - cpu_wait=0, owner_q=NONE, and the held mem_addr/mem_din registers are cleared to 0.
  - While rst_n=0, the gnts are forced to 0 and mem_bwe=00.
  - Reset in the cycle after a read grant squashes the pending rvalid.
- Simultaneous events: at most one gnt is ever high. Both requesting with cpu_wait<MAX gives video the grant and increments cpu_wait.
- Worst-case CPU latency: MAX_CPU_WAIT+1 cycles from request to grant under continuous video load.

Decomposition:
- Package cozy_mem_pkg: BWE_READ=2'b00, BWE_BYTE=2'b01, BWE_WORD=2'b11; enum owner_t {OWN_NONE, OWN_CPU, OWN_VID}.
- One natural sub-module, cozy_starve_counter: a saturating counter with clear, inc, rst_n and a sat flag.
- All other logic stays flat in cozy_mem_arbiter.

Test Plan:
1. rst_n=0 held with cpu_req=vid_req=1 -> cpu_gnt=vid_gnt=0, mem_bwe=00, both rvalid=0, mem_addr=0x0000.
2. CPU-only read: addr 0x0010, bwe=00, RAM word 0x1234 -> cpu_gnt=1 same cycle, cpu_rvalid=1 next cycle with cpu_rdata=0x1234, vid_rvalid=0.
3. Both request continuously, MAX_CPU_WAIT=4 -> vid_gnt on cycles 0-3, cpu_gnt on cycle 4, then vid_gnt again; the pattern repeats every 5 cycles.
4. CPU byte write: addr 0x0021, wdata 0x00AB, bwe=01 -> mem_bwe=01, mem_addr=0x0021, no cpu_rvalid. A later vid read of 0x0020 returns vid_rdata[15:8]=0xAB.
5. Video read granted at cycle N with rst_n=0 at cycle N+1 -> vid_rvalid=0 at N+1; counters and owner_q cleared.
6. cpu_bwe=10 at addr 0x0004 -> mem_bwe=00, cpu_rvalid=1 next cycle with RAM contents; RAM is unchanged.

Source files
------------

// File: rtl/cozy_mem_pkg.sv
// cozy_mem_pkg: shared encodings for the cozy RAM arbiter
package cozy_mem_pkg;
  localparam logic [1:0] BWE_READ = 2'b00;
  localparam logic [1:0] BWE_BYTE = 2'b01;
  localparam logic [1:0] BWE_WORD = 2'b11;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_VID = 2'd2} owner_t;
endpackage

// File: rtl/cozy_starve_counter.sv
// cozy_starve_counter: saturating wait counter with clear and a saturation flag
module cozy_starve_counter #(
  parameter int MAX = 4,
  parameter int W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic sat
);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    sat = cnt_q == MAX_V;
    cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cozy_mem_arbiter.sv
// cozy_mem_arbiter: video-priority RAM arbiter with bounded CPU starvation
module cozy_mem_arbiter
  import cozy_mem_pkg::*;
#(
  parameter int MAX_CPU_WAIT = 4,
  parameter int WAIT_W = (MAX_CPU_WAIT > 0) ? $clog2(MAX_CPU_WAIT + 1) : 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_bwe,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_gnt,
  output logic        vid_rvalid,
  output logic [15:0] vid_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_bwe,
  input  logic [15:0] mem_dout
);
  logic cpu_sat;
  logic [1:0] cpu_bwe_n;
  logic [15:0] addr_q, addr_d, din_q, din_d;
  owner_t owner_q, owner_d;
  cozy_starve_counter #(.MAX(MAX_CPU_WAIT), .W(WAIT_W)) u_starve (
    .clk(clk),
    .rst_n(rst_n),
    .clr(cpu_gnt | ~cpu_req),
    .inc(cpu_req & ~cpu_gnt),
    .sat(cpu_sat)
  );
  // Idle cycles replay the last address/data so the RAM never sees a stray write
  always_comb begin
    cpu_bwe_n = (cpu_bwe == 2'b10) ? BWE_READ : cpu_bwe;
    cpu_gnt = rst_n & cpu_req & (cpu_sat | ~vid_req);
    vid_gnt = rst_n & vid_req & ~cpu_gnt;
    mem_addr = cpu_gnt ? cpu_addr : vid_gnt ? vid_addr : addr_q;
    mem_din = cpu_gnt ? cpu_wdata : vid_gnt ? 16'h0000 : din_q;
    mem_bwe = cpu_gnt ? cpu_bwe_n : BWE_READ;
    addr_d = mem_addr;
    din_d = mem_din;
    owner_d = (cpu_gnt && cpu_bwe_n == BWE_READ) ? OWN_CPU : vid_gnt ? OWN_VID : OWN_NONE;
    cpu_rvalid = rst_n & (owner_q == OWN_CPU);
    vid_rvalid = rst_n & (owner_q == OWN_VID);
    cpu_rdata = mem_dout;
    vid_rdata = mem_dout;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr_q <= '0;
      din_q <= '0;
      owner_q <= OWN_NONE;
    end else begin
      addr_q <= addr_d;
      din_q <= din_d;
      owner_q <= owner_d;
    end
endmodule
